// File: rtl/pc_pkg.sv
// Shared CPU definitions used by the program-counter register and its neighbours.
package pc_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_BYTES      = 4;

   typedef logic [31:0] addr_t;

endpackage : pc_pkg

// File: rtl/pc.sv
// Program-counter register of the single-cycle MIPS datapath: loads nextPC when
// PCWre is high, holds otherwise, and exposes PC+4 and a misalignment flag.
module pc
   import pc_pkg::*;
#(
   parameter int                WIDTH    = 32,
   parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PCWre,
   input  logic [WIDTH-1:0] nextPC,
   output logic [WIDTH-1:0] curPC,
   output logic [WIDTH-1:0] pcPlus4,
   output logic             misaligned
);

   // The initialiser gives simulation a defined PC before the first edge.
   logic [WIDTH-1:0] curPc_q = RESET_PC;
   logic [WIDTH-1:0] curPc_d;

   always_comb begin
      curPc_d = curPc_q;
      if (PCWre) begin
         curPc_d = nextPC;
      end
   end

   // Reset is tested first so an unknown nextPC can never leak in while RST is high.
   always_ff @(posedge CLK) begin
      if (RST) begin
         curPc_q <= RESET_PC;
      end else begin
         curPc_q <= curPc_d;
      end
   end

   assign curPC      = curPc_q;
   assign pcPlus4    = curPc_q + WIDTH'(INSTR_BYTES);
   assign misaligned = |curPc_q[1:0];

endmodule : pc

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed scenarios followed by random traffic,
// all compared against a simple architectural model of the program counter.
module tb_pc;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        PCWre = 1'b0;
   logic [31:0] nextPC = 32'h0;
   logic [31:0] curPC;
   logic [31:0] pcPlus4;
   logic        misaligned;

   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] expPc = 32'h0;

   pc #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PCWre      (PCWre),
      .nextPC     (nextPC),
      .curPC      (curPC),
      .pcPlus4    (pcPlus4),
      .misaligned (misaligned)
   );

   always #5 CLK = ~CLK;

   // Drive inputs on the falling edge, let one rising edge happen, then update the model.
   task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] next);
      @(negedge CLK);
      RST    = rst;
      PCWre  = we;
      nextPC = next;
      @(posedge CLK);
      #1;
      if (rst)
         expPc = 32'h0;
      else if (we)
         expPc = next;
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] expPlus4;
      logic        expMis;
      expPlus4 = expPc + 32'd4;
      expMis   = (expPc % 4) != 0;
      compared++;
      assert (curPC === expPc) else begin
         mismatched++;
         $error("[TB] FAIL %s curPC observed %h expected %h", tag, curPC, expPc);
      end
      compared++;
      assert (pcPlus4 === expPlus4) else begin
         mismatched++;
         $error("[TB] FAIL %s pcPlus4 observed %h expected %h", tag, pcPlus4, expPlus4);
      end
      compared++;
      assert (misaligned === expMis) else begin
         mismatched++;
         $error("[TB] FAIL %s misaligned observed %b expected %b", tag, misaligned, expMis);
      end
   endtask

   initial begin
      logic        rndRst;
      logic        rndWe;
      logic [31:0] rndNext;

      #1;
      checkOutput("power_up");

      applyStimulus(1'b1, 1'b1, 32'd4);
      checkOutput("reset");

      applyStimulus(1'b0, 1'b1, 32'd4);
      checkOutput("load_4");
      nextPC = 32'd99;
      PCWre  = 1'b0;
      #1;
      checkOutput("mid_cycle_change");
      PCWre  = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'd8);
      checkOutput("load_8");

      applyStimulus(1'b0, 1'b0, 32'd12);
      checkOutput("hold_1");
      applyStimulus(1'b0, 1'b0, 32'd12);
      checkOutput("hold_2");
      applyStimulus(1'b0, 1'b1, 32'd12);
      checkOutput("load_12");

      applyStimulus(1'b1, 1'b1, 32'd16);
      checkOutput("priority_reset");
      applyStimulus(1'b0, 1'b1, 32'd16);
      checkOutput("resume_16");

      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap");
      applyStimulus(1'b0, 1'b1, 32'h0000_0006);
      checkOutput("misaligned_6");

      applyStimulus(1'b1, 1'b1, 32'hxxxx_xxxx);
      checkOutput("reset_x_next");

      for (int i = 0; i < 300; i++) begin
         rndRst  = ($urandom_range(0, 9) == 0);
         rndWe   = $urandom_range(0, 1) == 1;
         rndNext = $urandom();
         if ($urandom_range(0, 3) != 0)
            rndNext[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0)
            rndNext = 32'hFFFF_FFFC;
         applyStimulus(rndRst, rndWe, rndNext);
         checkOutput("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_pc
